// File: rtl/console_pkg.sv
// Shared types and constants for the text console sequencer and its cursor.
package console_pkg;

  localparam int unsigned NUM_ROWS_DEF = 3;
  localparam int unsigned NUM_COLS_DEF = 10;
  localparam int unsigned CHAR_W       = 7;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VBL,
    SCROLL,
    CLEAR_ROW,
    CLEAR_ALL
  } state_e;

  typedef enum logic {
    OP_SCROLL,
    OP_CLEAR_ALL
  } op_e;

  // One-hot cursor command decoded from an accepted stream byte
  typedef struct packed {
    logic put;
    logic lf;
    logic cr;
    logic bs;
    logic home;
  } cur_cmd_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor row/column registers with wrap, newline, carriage return and backspace.
module console_cursor
  import console_pkg::*;
#(
  parameter int unsigned NUM_ROWS = NUM_ROWS_DEF,
  parameter int unsigned NUM_COLS = NUM_COLS_DEF,
  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int unsigned COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  cur_cmd_t         cmd,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             scroll_req
);

  logic [ROW_W-1:0] row_d;
  logic [COL_W-1:0] col_d;
  logic             newline;
  logic             last_col;
  logic             last_row;

  assign last_col = (cur_col == COL_W'(NUM_COLS - 1));
  assign last_row = (cur_row == ROW_W'(NUM_ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_row <= '0;
      cur_col <= '0;
    end else begin
      cur_row <= row_d;
      cur_col <= col_d;
    end
  end

  // A newline on the last row leaves the cursor there and asks for a scroll
  always_comb begin
    row_d      = cur_row;
    col_d      = cur_col;
    newline    = 1'b0;
    scroll_req = 1'b0;
    if (cmd.home) begin
      row_d = '0;
      col_d = '0;
    end else if (cmd.put) begin
      if (last_col) begin
        col_d   = '0;
        newline = 1'b1;
      end else begin
        col_d = cur_col + COL_W'(1);
      end
    end else if (cmd.lf) begin
      col_d   = '0;
      newline = 1'b1;
    end else if (cmd.cr) begin
      col_d = '0;
    end else if (cmd.bs && (cur_col != '0)) begin
      col_d = cur_col - COL_W'(1);
    end
    if (newline) begin
      if (last_row) scroll_req = 1'b1;
      else          row_d      = cur_row + ROW_W'(1);
    end
  end

endmodule

// File: rtl/console_seq_ctrl.sv
// Terminal-style sequencer owning the text buffer write port: cursor handling,
// vsync-aligned scroll/clear sequences and host-priority write arbitration.
module console_seq_ctrl
  import console_pkg::*;
#(
  parameter int unsigned NUM_ROWS    = NUM_ROWS_DEF,
  parameter int unsigned NUM_COLS    = NUM_COLS_DEF,
  parameter int unsigned ADDR_W      = 5,
  parameter bit          SYNC_SCROLL = 1'b1,
  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int unsigned COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ch_valid,
  input  logic [7:0]        ch_data,
  output logic              ch_ready,
  input  logic              hw_req,
  input  logic [ADDR_W-1:0] hw_addr,
  input  logic [6:0]        hw_data,
  output logic              hw_ack,
  input  logic              vsync,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [6:0]        buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [6:0]        buf_rdata,
  output logic [ROW_W-1:0]  cur_row,
  output logic [COL_W-1:0]  cur_col,
  output logic              busy
);

  localparam int unsigned CELLS  = NUM_ROWS * NUM_COLS;
  localparam int unsigned COPY_N = NUM_COLS * (NUM_ROWS - 1);

  state_e            state, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              vsync_q;
  logic              vsync_rise;
  logic              accept;
  logic              scroll_req;
  logic              start;
  logic [ADDR_W-1:0] cell_addr;
  cur_cmd_t          cmd;

  // Host wins the port; the stream is only taken while the engine is idle
  assign hw_ack     = rst_n && hw_req;
  assign ch_ready   = rst_n && (state == IDLE) && !hw_req;
  assign accept     = ch_valid && ch_ready;
  assign busy       = (state != IDLE);
  assign vsync_rise = vsync && !vsync_q;
  assign cell_addr  = ADDR_W'(cur_row) * ADDR_W'(NUM_COLS) + ADDR_W'(cur_col);
  assign start      = cmd.home || scroll_req;

  always_comb begin
    cmd = '0;
    if (accept) begin
      cmd.put  = is_printable(ch_data);
      cmd.lf   = (ch_data == CH_LF);
      cmd.cr   = (ch_data == CH_CR);
      cmd.bs   = (ch_data == CH_BS);
      cmd.home = (ch_data == CH_FF);
    end
  end

  console_cursor #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS)
  ) u_cursor (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .scroll_req (scroll_req)
  );

  // State register plus the sequence index, pending op and vsync history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= OP_SCROLL;
      idx_q   <= '0;
      vsync_q <= 1'b0;
    end else begin
      state   <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      vsync_q <= vsync;
    end
  end

  // Next state; one index runs through the copy and then the cleared row
  always_comb begin
    state_d = state;
    op_d    = op_q;
    idx_d   = idx_q;
    case (state)
      IDLE: begin
        if (start) begin
          op_d  = cmd.home ? OP_CLEAR_ALL : OP_SCROLL;
          idx_d = '0;
          if (SYNC_SCROLL) state_d = WAIT_VBL;
          else             state_d = cmd.home ? CLEAR_ALL : SCROLL;
        end
      end
      WAIT_VBL: begin
        if (vsync_rise) begin
          state_d = (op_q == OP_CLEAR_ALL) ? CLEAR_ALL : SCROLL;
          idx_d   = '0;
        end
      end
      SCROLL: begin
        if (!hw_req) begin
          idx_d = idx_q + ADDR_W'(1);
          if (idx_q == ADDR_W'(COPY_N - 1)) state_d = CLEAR_ROW;
        end
      end
      CLEAR_ROW, CLEAR_ALL: begin
        if (!hw_req) begin
          if (idx_q == ADDR_W'(CELLS - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer port: host write, else engine step, else a printable from the stream
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = '0;
    buf_wdata = '0;
    buf_raddr = '0;
    if (state == SCROLL) buf_raddr = idx_q + ADDR_W'(NUM_COLS);
    if (hw_ack) begin
      buf_we    = 1'b1;
      buf_waddr = hw_addr;
      buf_wdata = hw_data;
    end else begin
      case (state)
        IDLE: begin
          if (cmd.put) begin
            buf_we    = 1'b1;
            buf_waddr = cell_addr;
            buf_wdata = ch_data[6:0];
          end
        end
        SCROLL: begin
          buf_we    = 1'b1;
          buf_waddr = idx_q;
          buf_wdata = buf_rdata;
        end
        CLEAR_ROW, CLEAR_ALL: begin
          buf_we    = 1'b1;
          buf_waddr = idx_q;
          buf_wdata = 7'(CH_SPACE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_console_seq_ctrl.sv
// Bench for console_seq_ctrl: an immediate-update instance and a vsync-aligned
// instance share stimulus and are checked every cycle against a cell-level model.
module tb_console_seq_ctrl;

  localparam int COLS  = 10;
  localparam int ROWS  = 3;
  localparam int CELLS = ROWS * COLS;
  localparam int COPY  = COLS * (ROWS - 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ch_valid;
  logic [7:0] ch_data;
  logic       hw_req;
  logic [4:0] hw_addr;
  logic [6:0] hw_data;
  logic       vsync;

  logic [1:0]      rdy, ack, we, busy;
  logic [1:0][4:0] waddr, raddr;
  logic [1:0][6:0] wdata, rdata;
  logic [1:0][1:0] crow;
  logic [1:0][3:0] ccol;

  logic [6:0] ram  [2][32];
  logic [6:0] snap [2][32];
  logic       ram_init;

  int checks = 0;
  int errors = 0;

  // Model state: expected cells, cursor and engine progress per instance
  logic [6:0] ref_mem [2][32];
  int m_row [2];
  int m_col [2];
  int m_k   [2];
  int m_op  [2];
  bit m_act [2];
  bit m_wait[2];
  bit m_pvs [2];
  bit m_sync[2];

  console_seq_ctrl #(.NUM_ROWS(3), .NUM_COLS(10), .ADDR_W(5), .SYNC_SCROLL(1'b0)) u_async (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(rdy[0]),
    .hw_req(hw_req), .hw_addr(hw_addr), .hw_data(hw_data), .hw_ack(ack[0]), .vsync(vsync),
    .buf_we(we[0]), .buf_waddr(waddr[0]), .buf_wdata(wdata[0]), .buf_raddr(raddr[0]),
    .buf_rdata(rdata[0]), .cur_row(crow[0]), .cur_col(ccol[0]), .busy(busy[0]));

  console_seq_ctrl #(.NUM_ROWS(3), .NUM_COLS(10), .ADDR_W(5), .SYNC_SCROLL(1'b1)) u_sync (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(rdy[1]),
    .hw_req(hw_req), .hw_addr(hw_addr), .hw_data(hw_data), .hw_ack(ack[1]), .vsync(vsync),
    .buf_we(we[1]), .buf_waddr(waddr[1]), .buf_wdata(wdata[1]), .buf_raddr(raddr[1]),
    .buf_rdata(rdata[1]), .cur_row(crow[1]), .cur_col(ccol[1]), .busy(busy[1]));

  assign rdata[0] = ram[0][raddr[0]];
  assign rdata[1] = ram[1][raddr[1]];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_init) begin
        for (int i = 0; i < 32; i++) ram[d][i] <= 7'h2E;
      end else if (we[d]) begin
        ram[d][waddr[d]] <= wdata[d];
      end
    end
  end

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", nm, d, act, exp);
    end
  endtask

  task automatic start_op(input int d, input int op);
    m_op[d] = op;
    m_k[d]  = 0;
    if (m_sync[d]) m_wait[d] = 1'b1;
    else           m_act[d]  = 1'b1;
  endtask

  // Predict this cycle's outputs, compare, then advance to the next edge
  task automatic model_step(input int d);
    int busy_e, rdy_e, acc, we_e, wa_e, wd_e, ra_e;
    if (ram_init) for (int i = 0; i < 32; i++) ref_mem[d][i] = 7'h2E;
    if (!rst_n) begin
      chk("rst_ready", d, int'(rdy[d]), 0);
      chk("rst_busy",  d, int'(busy[d]), 0);
      chk("rst_we",    d, int'(we[d]), 0);
      chk("rst_row",   d, int'(crow[d]), 0);
      chk("rst_col",   d, int'(ccol[d]), 0);
      m_row[d] = 0; m_col[d] = 0; m_k[d] = 0;
      m_act[d] = 1'b0; m_wait[d] = 1'b0; m_pvs[d] = 1'b0;
      return;
    end
    busy_e = (m_act[d] || m_wait[d]) ? 1 : 0;
    rdy_e  = (busy_e == 0 && !hw_req) ? 1 : 0;
    acc    = (rdy_e == 1 && ch_valid) ? 1 : 0;
    ra_e   = (m_act[d] && m_op[d] == 0 && m_k[d] < COPY) ? m_k[d] + COLS : 0;
    we_e = 0; wa_e = 0; wd_e = 0;
    if (hw_req) begin
      we_e = 1; wa_e = int'(hw_addr); wd_e = int'(hw_data);
    end else if (m_act[d]) begin
      we_e = 1; wa_e = m_k[d];
      wd_e = (m_op[d] == 0 && m_k[d] < COPY) ? int'(ref_mem[d][m_k[d] + COLS]) : 'h20;
    end else if (acc == 1 && ch_data >= 8'h20 && ch_data <= 8'h7E) begin
      we_e = 1; wa_e = m_row[d] * COLS + m_col[d]; wd_e = int'(ch_data[6:0]);
    end
    chk("ch_ready", d, int'(rdy[d]), rdy_e);
    chk("hw_ack",   d, int'(ack[d]), int'(hw_req));
    chk("busy",     d, int'(busy[d]), busy_e);
    chk("buf_we",   d, int'(we[d]), we_e);
    chk("buf_raddr", d, int'(raddr[d]), ra_e);
    if (we_e == 1) begin
      chk("buf_waddr", d, int'(waddr[d]), wa_e);
      chk("buf_wdata", d, int'(wdata[d]), wd_e);
    end
    chk("cur_row", d, int'(crow[d]), m_row[d]);
    chk("cur_col", d, int'(ccol[d]), m_col[d]);

    if (we_e == 1) ref_mem[d][wa_e] = 7'(wd_e);
    if (m_act[d] && !hw_req) begin
      m_k[d]++;
      if (m_k[d] == CELLS) m_act[d] = 1'b0;
    end
    if (m_wait[d] && vsync && !m_pvs[d]) begin
      m_wait[d] = 1'b0; m_act[d] = 1'b1; m_k[d] = 0;
    end
    if (acc == 1) begin
      if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
        if (m_col[d] < COLS - 1) m_col[d]++;
        else begin
          m_col[d] = 0;
          if (m_row[d] < ROWS - 1) m_row[d]++;
          else start_op(d, 0);
        end
      end else if (ch_data == 8'h0A) begin
        m_col[d] = 0;
        if (m_row[d] < ROWS - 1) m_row[d]++;
        else start_op(d, 0);
      end else if (ch_data == 8'h0D) begin
        m_col[d] = 0;
      end else if (ch_data == 8'h08) begin
        if (m_col[d] > 0) m_col[d]--;
      end else if (ch_data == 8'h0C) begin
        m_row[d] = 0; m_col[d] = 0;
        start_op(d, 1);
      end
    end
    m_pvs[d] = vsync;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for both engines, pulsing vsync so the aligned instance can proceed
  task automatic wait_idle();
    int n = 0;
    while (busy != 2'b00 && n < 600) begin
      vsync = ((n % 8) >= 4);
      tick();
      n++;
    end
    if (n > 0) vsync = 1'b0;
    chk("wait_idle", 0, int'(busy), 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_idle();
    ch_valid = 1'b1;
    ch_data  = b;
    tick();
    ch_valid = 1'b0;
    ch_data  = 8'h00;
  endtask

  task automatic host_write(input int a, input int v);
    hw_req  = 1'b1;
    hw_addr = 5'(a);
    hw_data = 7'(v);
    tick();
    hw_req  = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int nw;
    m_sync[0] = 1'b0;
    m_sync[1] = 1'b1;
    rst_n = 1'b0; ram_init = 1'b1;
    ch_valid = 1'b0; ch_data = 8'h00;
    hw_req = 1'b0; hw_addr = '0; hw_data = '0; vsync = 1'b0;
    tick(); tick();
    ram_init = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_ready", d, int'(rdy[d]), 1);
      chk("post_rst_col", d, int'(ccol[d]), 0);
    end

    // "AB" lands in cells 0 and 1 on back-to-back accepts
    send_byte(8'h41);
    send_byte(8'h42);
    for (int d = 0; d < 2; d++) begin
      chk("ab_cell0", d, int'(ram[d][0]), 'h41);
      chk("ab_cell1", d, int'(ram[d][1]), 'h42);
      chk("ab_col", d, int'(ccol[d]), 2);
      chk("ab_row", d, int'(crow[d]), 0);
    end

    // Preload rows 1/2, fill row 0, two LFs force a scroll
    for (int i = 0; i < 10; i++) host_write(10 + i, 'h30 + i);
    for (int i = 0; i < 10; i++) host_write(20 + i, 'h61 + i);
    send_byte(8'h0D);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h4B + i));
    send_byte(8'h0A);
    chk("lf_row", 0, int'(crow[0]), 2);
    send_byte(8'h0A);
    cnt = 0;
    while (busy[0] && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("scroll_busy_cycles", 0, cnt, 30);
    wait_idle();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 10; i++) begin
        chk("scroll_row0", d, int'(ram[d][i]), 'h30 + i);
        chk("scroll_row1", d, int'(ram[d][10 + i]), 'h61 + i);
        chk("scroll_row2", d, int'(ram[d][20 + i]), 'h20);
      end
      chk("scroll_cur_row", d, int'(crow[d]), 2);
      chk("scroll_cur_col", d, int'(ccol[d]), 0);
    end

    // Aligned instance must sit still while vsync stays high
    vsync = 1'b1;
    tick();
    send_byte(8'h0A);
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      if (we[1]) nw++;
      tick();
    end
    chk("vbl_hold_writes", 1, nw, 0);
    chk("vbl_hold_busy", 1, int'(busy[1]), 1);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    chk("vbl_edge_cycle_we", 1, int'(we[1]), 0);
    tick();
    chk("vbl_first_we", 1, int'(we[1]), 1);
    chk("vbl_first_addr", 1, int'(waddr[1]), 0);
    wait_idle();
    for (int d = 0; d < 2; d++) begin
      chk("vbl_row0", d, int'(ram[d][0]), 'h61);
      chk("vbl_row1", d, int'(ram[d][10]), 'h20);
    end

    // Three host cycles mid-scroll, after cell 5 was copied
    send_byte(8'h0A);
    cnt = 0;
    while (busy[0] && cnt < 100) begin
      cnt++;
      hw_req  = (cnt >= 9 && cnt <= 11);
      hw_addr = 5'd5;
      hw_data = 7'h58;
      tick();
    end
    hw_req = 1'b0;
    chk("stall_busy_cycles", 0, cnt, 33);
    chk("stall_host_cell", 0, int'(ram[0][5]), 'h58);
    chk("stall_neighbour", 0, int'(ram[0][4]), 'h20);
    wait_idle();

    // Backspace at column 0 is inert; a later BS lets Y replace X
    send_byte(8'h0C);
    send_byte(8'h08);
    send_byte(8'h58);
    send_byte(8'h08);
    send_byte(8'h59);
    for (int d = 0; d < 2; d++) begin
      chk("bs_cell0", d, int'(ram[d][0]), 'h59);
      chk("bs_cell1", d, int'(ram[d][1]), 'h20);
      chk("bs_row", d, int'(crow[d]), 0);
      chk("bs_col", d, int'(ccol[d]), 1);
    end

    // Reset during clear-all after twelve cells
    wait_idle();
    for (int i = 0; i < CELLS; i++) host_write(i, 'h41 + i);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) snap[d][i] = ram[d][i];
    send_byte(8'h0C);
    for (int i = 0; i < 12; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 0, int'(busy[0]), 0);
    chk("abort_we", 0, int'(we[0]), 0);
    chk("abort_row", 0, int'(crow[0]), 0);
    chk("abort_col", 0, int'(ccol[0]), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < CELLS; i++) begin
      if (i < 12) chk("abort_cleared", 0, int'(ram[0][i]), 'h20);
      else        chk("abort_kept", 0, int'(ram[0][i]), int'(snap[0][i]));
      chk("abort_sync_kept", 1, int'(ram[1][i]), int'(snap[1][i]));
    end

    tick(); tick();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < CELLS; i++)
        chk("final_mem", d, int'(ram[d][i]), int'(ref_mem[d][i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
